wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects writeback data, decodes the destination register from the instruction word, and commits it to a 16x16 general register file.
- Handles the dedicated r0 write path (r0 data and r0 write strobe) and exposes two combinational read ports to the decode stage.
- Also maintains a retired-write counter used by the debug/trace logic.

Parameters:
- DATA_W, 16, width of every register and data path.
- NUM_REGS, 16, number of general registers.
- ADDR_W, 4, register index width; must satisfy 2**ADDR_W == NUM_REGS.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- regWrite  input  1  commit selected data to register rd this cycle.
- mux3sel  input  1  writeback data select: 0 = dOut (ALU result), 1 = dIn (memory read data).
- r0Write  input  1  commit r0data to register 0 this cycle.
- instruction  input  DATA_W  instruction word; rd = instruction[11:8].
- dOut  input  DATA_W  ALU result.
- dIn  input  DATA_W  memory load data.
- r0data  input  DATA_W  dedicated r0 write data.
- rdAddrA  input  ADDR_W  read port A index.
- rdAddrB  input  ADDR_W  read port B index.
- rdDataA  output  DATA_W  read port A data.
- rdDataB  output  DATA_W  read port B data.
- wbData  output  DATA_W  registered copy of the last committed general-path data.
- wbValid  output  1  high for exactly one cycle after any commit.
- retireCount  output  16  count of cycles with at least one commit.

Behaviour:
- Reset (rst=1 at posedge clk):
  - All NUM_REGS registers, wbData, wbValid and retireCount go to 0.
  - Reset has priority over every write, including one in the same cycle.
  - Reset mid-stream drops any commit presented that cycle.
- Writeback data: wdata = mux3sel ? dIn : dOut (combinational). rd = instruction[11:8].
- Commit on posedge clk when rst=0:
  - regWrite=1: reg[rd] <= wdata.
  - r0Write=1: reg[0] <= r0data.
  - Both asserted and rd==0: r0Write wins; reg[0] <= r0data.
  - Both asserted and rd!=0: both writes occur in the same cycle.
- wbData <= wdata when regWrite=1; otherwise holds.
- wbValid <= regWrite | r0Write; cleared the next cycle unless another commit occurs.
- retireCount:
  - Increments by 1 on each cycle with regWrite|r0Write, never by 2.
  - Wraps 0xFFFF -> 0x0000 with no flag.
- Read ports:
  - Purely combinational from array state; no read latency.
  - Same-cycle write visibility is governed by the optional feature below.
- Latency: a write presented in cycle N is architecturally visible in cycle N+1 in all configurations.
- Inputs are driven directly by the MEM/WB pipeline register; there is no handshake. A commit is accepted every cycle.
- X on regWrite or r0Write is not tolerated; the bench drives known values after reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined (write-through bypass):
  - If rdAddrX == rd and regWrite=1 in the same cycle, rdDataX = wdata.
  - If rdAddrX == 0 and r0Write=1, rdDataX = r0data. This takes priority over the regWrite bypass when rd==0, matching the commit priority.
  - Removes the decode/writeback structural hazard.
- Undefined:
  - rdDataX always reflects array contents only.
  - A same-cycle write is seen one cycle later.
  - Hazard resolution is left to the stall logic.

Test Plan:
- Reset then read all: rst=1 for 2 cycles, sweep rdAddrA 0..15 -> rdDataA=0x0000 for every index; retireCount=0, wbValid=0.
- ALU vs load select:
  - instruction=0x0500, regWrite=1, mux3sel=0, dOut=0x1234, dIn=0xBEEF -> next cycle reg5=0x1234, wbData=0x1234, wbValid=1.
  - Repeat with mux3sel=1 -> reg5=0xBEEF.
- r0 priority: instruction=0x0000, regWrite=1, r0Write=1, dOut=0xAAAA, r0data=0x5555 -> reg0=0x5555, retireCount +1 only.
- Dual commit: rd=3, regWrite=1, dOut=0x0F0F, r0Write=1, r0data=0x7777 -> reg3=0x0F0F and reg0=0x7777 after one edge.
- Same-cycle read of rd=7, dOut=0x4321, rdAddrB=7:
  - WB_BYPASS_EN defined -> rdDataB=0x4321 in the write cycle.
  - WB_BYPASS_EN undefined -> old value in the write cycle, 0x4321 the next cycle.
- Counter wrap and reset mid-stream:
  - Force retireCount to 0xFFFF via 65535 commits, commit once more -> 0x0000.
  - Assert rst in the same cycle as regWrite to rd=9 -> reg9 stays 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback data, commits it to the 16x16 register file,
// and provides two combinational read ports. Define WB_BYPASS_EN for write-through reads.
module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic              mux3sel,
  input  logic              r0Write,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] dOut,
  input  logic [DATA_W-1:0] dIn,
  input  logic [DATA_W-1:0] r0data,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  output logic [DATA_W-1:0] wbData,
  output logic              wbValid,
  output logic [15:0]       retireCount
);

  if (2**ADDR_W != NUM_REGS) begin : gBadSize
    $error("wb_regfile: 2**ADDR_W must equal NUM_REGS");
  end

  logic [DATA_W-1:0]                 regFile [NUM_REGS];
  logic [NUM_REGS-1:0][DATA_W-1:0]   regNext;
  logic [NUM_REGS-1:0]               regWe;
  logic [DATA_W-1:0]                 wdata;
  logic [ADDR_W-1:0]                 rd;
  logic                              unusedBits;

  assign wdata      = mux3sel ? dIn : dOut;
  assign rd         = instruction[8 +: ADDR_W];
  assign unusedBits = ^instruction;

  // r0 has two write sources; the dedicated r0 path wins when both target it.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gRegWr
    if (gi == 0) begin : gR0
      assign regWe[gi]   = r0Write | (regWrite & (rd == '0));
      assign regNext[gi] = r0Write ? r0data : wdata;
    end else begin : gRn
      assign regWe[gi]   = regWrite & (rd == ADDR_W'(gi));
      assign regNext[gi] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
      wbData      <= '0;
      wbValid     <= 1'b0;
      retireCount <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (regWe[i]) regFile[i] <= regNext[i];
      end
      if (regWrite) wbData <= wdata;
      wbValid <= regWrite | r0Write;
      // One increment per committing cycle, even for a dual commit.
      if (regWrite | r0Write) retireCount <= retireCount + 16'd1;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rdDataA = regFile[rdAddrA];
    if (regWrite && rdAddrA == rd) rdDataA = wdata;
    if (r0Write && rdAddrA == '0)  rdDataA = r0data;
    rdDataB = regFile[rdAddrB];
    if (regWrite && rdAddrB == rd) rdDataB = wdata;
    if (r0Write && rdAddrB == '0)  rdDataB = r0data;
  end
`else
  assign rdDataA = regFile[rdAddrA];
  assign rdDataB = regFile[rdAddrB];
`endif

endmodule
